// File: rtl/ram_port_arbiter_if.sv
// Request/grant/read-return bundle between two requesters, the arbiter and one RAM.
// Latency: none (wires only).
// Backpressure: requests are held by the requester until the matching grant is seen.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  // Requester A: game logic, read/write
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;
  // Requester B: display scanner, read-only
  logic                  b_req;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;
  // Board clear control
  logic                  clear_req;
  logic                  clear_busy;
  // RAM side
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_d;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q;

  // Arbiter view
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_addr, clear_req, ram_q,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, clear_busy,
    output ram_addr, ram_d, ram_we
  );

  // Requester / RAM view
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_addr, clear_req, ram_q,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, clear_busy,
    input  ram_addr, ram_d, ram_we
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of one single-port board RAM between game logic (A) and display scan (B).
// Latency: grant combinational in the request cycle; read data valid the following cycle.
// Backpressure: loser/blocked requester holds its request; clear sweep (RAM_ARB_CLEAR_EN) blocks both.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_LENGTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  ram_port_arbiter_if.slave  bus
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(RAM_LENGTH - 1);

  state_t                state_q, state_d;
  logic                  last_b_q, last_b_d;   // 1 = B was granted most recently
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;         // clear sweep cell
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;       // last address driven to the RAM
  logic                  a_rvalid_q, a_rvalid_d;
  logic                  b_rvalid_q, b_rvalid_d;
  logic                  a_win, b_win;
  logic                  clear_start;

`ifdef RAM_ARB_CLEAR_EN
  assign clear_start = bus.clear_req;
`else
  // Without the sweep the FSM never leaves IDLE and clear_req has no effect.
  logic unused_clear_req;
  assign clear_start      = 1'b0;
  assign unused_clear_req = bus.clear_req;
`endif

  // State, round-robin pointer, held address and read-return flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      last_b_q   <= 1'b1;
      cnt_q      <= '0;
      addr_q     <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  // Arbitration, RAM drive and next state; rst gates grants so nothing issues during reset
  always_comb begin
    state_d      = state_q;
    last_b_d     = last_b_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    a_win        = 1'b0;
    b_win        = 1'b0;
    bus.ram_we   = 1'b0;
    bus.ram_addr = addr_q;
    bus.ram_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (rst) begin
          // On a tie the requester that was not served last wins.
          if (bus.a_req && (!bus.b_req || last_b_q)) begin
            a_win = 1'b1;
          end else if (bus.b_req) begin
            b_win = 1'b1;
          end
          if (a_win) begin
            bus.ram_addr = bus.a_addr;
            bus.ram_d    = bus.a_wdata;
            bus.ram_we   = bus.a_we;
            addr_d       = bus.a_addr;
            last_b_d     = 1'b0;
          end else if (b_win) begin
            bus.ram_addr = bus.b_addr;
            addr_d       = bus.b_addr;
            last_b_d     = 1'b1;
          end
          // A grant in the same cycle still completes; the sweep begins next cycle.
          if (clear_start) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
          end
        end
      end
      ST_CLEAR: begin
        bus.ram_we   = 1'b1;
        bus.ram_addr = cnt_q;
        bus.ram_d    = '0;
        addr_d       = cnt_q;
        if (cnt_q == LAST_CELL) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    a_rvalid_d = a_win && !bus.a_we;
    b_rvalid_d = b_win;
  end

  assign bus.a_gnt      = a_win;
  assign bus.b_gnt      = b_win;
  assign bus.a_rvalid   = a_rvalid_q;
  assign bus.b_rvalid   = b_rvalid_q;
  assign bus.a_rdata    = bus.ram_q;
  assign bus.b_rdata    = bus.ram_q;
  assign bus.clear_busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised and directed traffic against a cycle-level reference model with a scoreboard.
// Latency: reads expected exactly one cycle after their grant.
// Backpressure: requesters hold requests until granted; every wait is bounded.
module tb_ram_port_arbiter;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int LEN = 16;
`ifdef RAM_ARB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_LENGTH(LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM with registered read address
  logic [DW-1:0] ram_mem [LEN] = '{default: '0};
  logic [AW-1:0] ram_raddr = '0;
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_d;
    ram_raddr <= bus.ram_addr;
  end
  assign bus.ram_q = ram_mem[ram_raddr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          a_gnt;
    logic          b_gnt;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    logic          chk_d;
    logic          busy;
  } cyc_t;
  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
  } rd_t;

  cyc_t          exp_q[$];
  rd_t           a_rd_q[$];
  rd_t           b_rd_q[$];
  int            cyc = 0;
  bit            m_last_b = 1'b1;
  int            clr_left = 0;
  logic [AW-1:0] m_last_addr = '0;
  logic [DW-1:0] m_mem [LEN] = '{default: '0};

  always @(negedge clk) begin : model
    cyc_t e;
    rd_t  r;
    int   win;
    cyc++;
    e = '0;
    if (!rst) begin
      m_last_b    = 1'b1;
      clr_left    = 0;
      m_last_addr = '0;
      a_rd_q.delete();
      b_rd_q.delete();
      e.chk_d     = 1'b1;
    end else if (clr_left > 0) begin
      e.we        = 1'b1;
      e.addr      = AW'(LEN - clr_left);
      e.d         = '0;
      e.chk_d     = 1'b1;
      e.busy      = 1'b1;
      m_mem[e.addr] = '0;
      m_last_addr = e.addr;
      clr_left--;
    end else begin
      if (bus.a_req && bus.b_req) win = m_last_b ? 1 : 2;
      else if (bus.a_req)         win = 1;
      else if (bus.b_req)         win = 2;
      else                        win = 0;
      e.addr = m_last_addr;
      if (win == 1) begin
        e.a_gnt = 1'b1;
        e.we    = bus.a_we;
        e.addr  = bus.a_addr;
        e.d     = bus.a_wdata;
        e.chk_d = 1'b1;
        if (bus.a_we) m_mem[bus.a_addr] = bus.a_wdata;
        else begin
          r.cyc = cyc + 1;
          r.d   = m_mem[bus.a_addr];
          a_rd_q.push_back(r);
        end
        m_last_b    = 1'b0;
        m_last_addr = bus.a_addr;
      end else if (win == 2) begin
        e.b_gnt = 1'b1;
        e.addr  = bus.b_addr;
        r.cyc   = cyc + 1;
        r.d     = m_mem[bus.b_addr];
        b_rd_q.push_back(r);
        m_last_b    = 1'b1;
        m_last_addr = bus.b_addr;
      end
      if (CLEAR_EN && bus.clear_req) clr_left = LEN;
    end
    exp_q.push_back(e);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    cyc_t e;
    bit   ea, eb;
    #1;
    if (exp_q.size() == 0) begin
      chk("exp_queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("a_gnt",      bus.a_gnt,      e.a_gnt);
      chk("b_gnt",      bus.b_gnt,      e.b_gnt);
      chk("ram_we",     bus.ram_we,     e.we);
      chk("ram_addr",   bus.ram_addr,   e.addr);
      chk("clear_busy", bus.clear_busy, e.busy);
      if (e.chk_d) chk("ram_d", bus.ram_d, e.d);
    end
    ea = (a_rd_q.size() > 0) && (a_rd_q[0].cyc == cyc);
    eb = (b_rd_q.size() > 0) && (b_rd_q[0].cyc == cyc);
    chk("a_rvalid", bus.a_rvalid, ea);
    chk("b_rvalid", bus.b_rvalid, eb);
    if (ea) begin
      chk("a_rdata", bus.a_rdata, a_rd_q[0].d);
      void'(a_rd_q.pop_front());
    end
    if (eb) begin
      chk("b_rdata", bus.b_rdata, b_rd_q[0].d);
      void'(b_rd_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic a_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    int w = 0;
    int idle_w = 0;
    bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = d;
    do begin
      @(negedge clk);
      w++;
      if (!bus.a_gnt && !bus.clear_busy) idle_w++;
    end while (!bus.a_gnt && w < 40);
    chk("a_gnt_wait", bus.a_gnt, 1'b1);
    chk("a_starve", (idle_w <= 1), 1'b1);
    @(posedge clk);
    #1;
    bus.a_req = 1'b0;
  endtask

  task automatic b_op(input logic [AW-1:0] addr);
    int w = 0;
    int idle_w = 0;
    bus.b_req = 1'b1; bus.b_addr = addr;
    do begin
      @(negedge clk);
      w++;
      if (!bus.b_gnt && !bus.clear_busy) idle_w++;
    end while (!bus.b_gnt && w < 40);
    chk("b_gnt_wait", bus.b_gnt, 1'b1);
    chk("b_starve", (idle_w <= 1), 1'b1);
    @(posedge clk);
    #1;
    bus.b_req = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear_req = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_req = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    // Reset held with both requesters asking: nothing may be granted.
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b1; bus.b_addr = '0; bus.clear_req = 1'b0;
    rst = 1'b0;
    idle(3);
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    rst = 1'b1;

    // Contention straight out of reset: A, B, A, B.
    fork
      begin a_op(1'b0, 4'd1, 8'h00); a_op(1'b0, 4'd2, 8'h00); end
      begin b_op(4'd1); b_op(4'd2); end
    join

    // Write then read back on A.
    a_op(1'b1, 4'd3, 8'hA5);
    a_op(1'b0, 4'd3, 8'h00);
    idle(2);

    if (CLEAR_EN) begin
      // Fill, sweep, read everything back through B.
      for (int i = 0; i < LEN; i++) a_op(1'b1, AW'(i), 8'hFF);
      pulse_clear();
      idle(17);
      for (int i = 0; i < LEN; i++) b_op(AW'(i));

      // clear_req in the same cycle as a B read, then a second pulse while busy.
      a_op(1'b1, 4'd7, 8'h77);
      bus.b_req = 1'b1; bus.b_addr = 4'd7; bus.clear_req = 1'b1;
      @(posedge clk);
      #1;
      bus.b_req = 1'b0; bus.clear_req = 1'b0;
      idle(3);
      pulse_clear();
      idle(16);

      // Reset in the middle of a sweep at counter 5.
      a_op(1'b1, 4'd9, 8'h99);
      pulse_clear();
      idle(5);
      rst = 1'b0;
      idle(2);
      rst = 1'b1;
      a_op(1'b1, 4'd6, 8'h5C);
      a_op(1'b0, 4'd6, 8'h00);
      a_op(1'b0, 4'd9, 8'h00);
    end else begin
      // Pulse must be ignored: no writes, arbitration unchanged.
      a_op(1'b1, 4'd5, 8'h3C);
      pulse_clear();
      idle(3);
      fork
        a_op(1'b0, 4'd5, 8'h00);
        b_op(4'd5);
      join
      rst = 1'b0;
      idle(2);
      rst = 1'b1;
    end

    // Randomised traffic from both requesters plus occasional clear pulses.
    fork
      repeat (40) begin
        idle($urandom_range(0, 2));
        a_op(1'($urandom_range(0, 1)), AW'($urandom_range(0, LEN - 1)), DW'($urandom_range(0, 255)));
      end
      repeat (40) begin
        idle($urandom_range(0, 2));
        b_op(AW'($urandom_range(0, LEN - 1)));
      end
      repeat (3) begin
        idle($urandom_range(20, 40));
        pulse_clear();
      end
    join

    idle(20);
    chk("a_rd_drain", a_rd_q.size(), 32'd0);
    chk("b_rd_drain", b_rd_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
